jtpang_sdram_resp: RTL and testbench

- Responder end of the four-bank ROM request interface used by the game's SDRAM glue.
- Accepts read requests from up to four bank requesters (ba_rd/baN_addr) and arbitrates them round-robin.
- Issues each granted read to a simple word-wide memory port, then returns the data with the ack/dst/dok/rdy strobes the requesters expect.
- Also services the download write path (prog_*), which has priority over all bank reads.

---
 rtl/jtpang_sdram_resp.sv | 125 ++++++++++++
 tb/tb_jtpang_sdram_resp.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtpang_sdram_resp.sv
// jtpang_sdram_resp: round-robin four-bank ROM read responder with a priority download write/read-back path
module jtpang_sdram_resp #(
  parameter int BURST = 2,
  parameter int AW = 22
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ba0_addr,
  input  logic [AW-1:0] ba1_addr,
  input  logic [AW-1:0] ba2_addr,
  input  logic [AW-1:0] ba3_addr,
  input  logic [3:0]    ba_rd,
  output logic [3:0]    ba_ack,
  output logic [3:0]    ba_dst,
  output logic [3:0]    ba_dok,
  output logic [3:0]    ba_rdy,
  output logic [15:0]   data_read,
  input  logic [AW-1:0] prog_addr,
  input  logic [1:0]    prog_ba,
  input  logic [15:0]   prog_data,
  input  logic [1:0]    prog_mask,
  input  logic          prog_we,
  input  logic          prog_rd,
  output logic          prog_ack,
  output logic          prog_rdy,
  output logic [AW+1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_we,
  output logic [15:0]   mem_din,
  output logic [1:0]    mem_mask,
  input  logic [15:0]   mem_dout,
  input  logic          mem_valid
);
  typedef enum logic [2:0] {IDLE, PWR, PRD, GRANT, ISSUE, WAIT, DONE} state_t;
  state_t st, st_d;
  logic [1:0] ptr, sel, bank, cnt, cnt_d;
  logic [AW-1:0] addr, sel_addr;
  logic [3:0] onehot;
  logic last;
  always_comb begin
    sel = ptr;
    for (int i = 3; i >= 0; i--)
      if (ba_rd[ptr + 2'(i)]) sel = ptr + 2'(i);
  end
  assign sel_addr = sel == 2'd0 ? ba0_addr : sel == 2'd1 ? ba1_addr : sel == 2'd2 ? ba2_addr : ba3_addr;
  assign last = cnt == 2'(BURST - 1);
  assign cnt_d = st == WAIT ? cnt + 2'd1 : cnt;
  assign onehot = 4'b1 << bank;
  always_comb begin
    st_d = st;
    case (st)
      IDLE:    st_d = prog_we ? PWR : prog_rd ? PRD : |ba_rd ? GRANT : IDLE;
      PWR:     st_d = DONE;
      PRD:     st_d = mem_valid ? DONE : PRD;
      GRANT:   st_d = ISSUE;
      ISSUE:   st_d = WAIT;
      WAIT:    st_d = !mem_valid ? WAIT : last ? DONE : ISSUE;
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      ptr <= '0;
      bank <= '0;
      cnt <= '0;
      addr <= '0;
      ba_ack <= '0;
      ba_dst <= '0;
      ba_dok <= '0;
      ba_rdy <= '0;
      data_read <= '0;
      prog_ack <= 1'b0;
      prog_rdy <= 1'b0;
      mem_rd <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_din <= '0;
      mem_mask <= 2'b11;
    end else begin
      st <= st_d;
      ba_ack <= '0;
      ba_dst <= '0;
      ba_dok <= '0;
      ba_rdy <= '0;
      prog_ack <= 1'b0;
      prog_rdy <= 1'b0;
      mem_rd <= 1'b0;
      mem_we <= 1'b0;
      if (st == IDLE && prog_we) begin
        prog_ack <= 1'b1;
        mem_we <= 1'b1;
        mem_addr <= {prog_ba, prog_addr};
        mem_din <= prog_data;
        mem_mask <= prog_mask;
      end else if (st == IDLE && prog_rd) begin
        prog_ack <= 1'b1;
        mem_rd <= 1'b1;
        mem_addr <= {prog_ba, prog_addr};
      end else if (st == IDLE && |ba_rd) begin
        ba_ack <= 4'b1 << sel;
        bank <= sel;
        addr <= sel_addr;
        cnt <= '0;
        ptr <= sel + 2'd1;
      end
      if (st_d == ISSUE) begin
        mem_rd <= 1'b1;
        mem_addr <= {bank, addr + AW'(cnt_d)};
        cnt <= cnt_d;
      end
      if (st == PWR) prog_rdy <= 1'b1;
      if (st == PRD && mem_valid) begin
        data_read <= mem_dout;
        prog_rdy <= 1'b1;
      end
      if (st == WAIT && mem_valid) begin
        data_read <= mem_dout;
        ba_dok <= onehot;
        ba_dst <= cnt == 2'd0 ? onehot : 4'd0;
        ba_rdy <= last ? onehot : 4'd0;
      end
    end
  end
endmodule

// File: tb/tb_jtpang_sdram_resp.sv
// tb_jtpang_sdram_resp: scoreboard bench for jtpang_sdram_resp
module tb_jtpang_sdram_resp;
  localparam int AW = 22;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [AW-1:0] ba0_addr = '0, ba1_addr = '0, ba2_addr = '0, ba3_addr = '0, prog_addr = '0;
  logic [3:0] ba_rd = '0, ba_rd_1 = '0;
  logic [1:0] prog_ba = '0, prog_mask = 2'b11;
  logic [15:0] prog_data = '0;
  logic prog_we = 1'b0, prog_rd = 1'b0;
  logic [3:0] ba_ack, ba_dst, ba_dok, ba_rdy, ba_ack_1, ba_dst_1, ba_dok_1, ba_rdy_1;
  logic [15:0] data_read, data_read_1, mem_din, mem_din_1;
  logic prog_ack, prog_rdy, mem_rd, mem_we, prog_ack_1, prog_rdy_1, mem_rd_1, mem_we_1;
  logic [AW+1:0] mem_addr, mem_addr_1;
  logic [1:0] mem_mask, mem_mask_1;
  logic [15:0] mem_dout = '0, mem_dout_1 = '0;
  logic mem_valid = 1'b0, mem_valid_1 = 1'b0;
  jtpang_sdram_resp u0 (
    .clk(clk), .rst(rst),
    .ba0_addr(ba0_addr), .ba1_addr(ba1_addr), .ba2_addr(ba2_addr), .ba3_addr(ba3_addr),
    .ba_rd(ba_rd), .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_dok(ba_dok), .ba_rdy(ba_rdy),
    .data_read(data_read),
    .prog_addr(prog_addr), .prog_ba(prog_ba), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_we(prog_we), .prog_rd(prog_rd), .prog_ack(prog_ack), .prog_rdy(prog_rdy),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_we(mem_we), .mem_din(mem_din),
    .mem_mask(mem_mask), .mem_dout(mem_dout), .mem_valid(mem_valid)
  );
  jtpang_sdram_resp #(.BURST(1)) u1 (
    .clk(clk), .rst(rst),
    .ba0_addr(ba0_addr), .ba1_addr(ba1_addr), .ba2_addr(ba2_addr), .ba3_addr(ba3_addr),
    .ba_rd(ba_rd_1), .ba_ack(ba_ack_1), .ba_dst(ba_dst_1), .ba_dok(ba_dok_1), .ba_rdy(ba_rdy_1),
    .data_read(data_read_1),
    .prog_addr(prog_addr), .prog_ba(prog_ba), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_we(1'b0), .prog_rd(1'b0), .prog_ack(prog_ack_1), .prog_rdy(prog_rdy_1),
    .mem_addr(mem_addr_1), .mem_rd(mem_rd_1), .mem_we(mem_we_1), .mem_din(mem_din_1),
    .mem_mask(mem_mask_1), .mem_dout(mem_dout_1), .mem_valid(mem_valid_1)
  );
  int lat = 1, cd = 0;
  logic pend = 1'b0, pend_1 = 1'b0, force_en = 1'b0;
  logic [15:0] force_v = '0;
  logic [AW+1:0] ra = '0, ra_1 = '0;
  function automatic logic [15:0] memf(input logic [AW+1:0] a);
    return a[15:0] ^ {a[AW+1:AW], 14'd0} ^ 16'h5A5A;
  endfunction
  always @(posedge clk) begin
    mem_valid <= 1'b0;
    if (mem_rd) begin
      pend <= 1'b1;
      cd <= lat;
      ra <= mem_addr;
    end else if (pend) begin
      if (cd <= 1) begin
        pend <= 1'b0;
        mem_valid <= 1'b1;
        mem_dout <= force_en ? force_v : memf(ra);
      end else cd <= cd - 1;
    end
  end
  always @(posedge clk) begin
    mem_valid_1 <= 1'b0;
    if (mem_rd_1) begin
      pend_1 <= 1'b1;
      ra_1 <= mem_addr_1;
    end else if (pend_1) begin
      pend_1 <= 1'b0;
      mem_valid_1 <= 1'b1;
      mem_dout_1 <= memf(ra_1);
    end
  end
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  logic [4:0] q_ack[$];
  logic [42:0] q_mem[$];
  logic [28:0] q_out[$];
  logic [15:0] exp_data = '0;
  logic mon_en = 1'b0;
  function automatic logic [77:0] outv();
    return {ba_ack, ba_dst, ba_dok, ba_rdy, data_read, prog_ack, prog_rdy, mem_rd, mem_we, mem_addr, mem_din, mem_mask};
  endfunction
  task automatic push_rd(input int b, input logic [AW-1:0] a);
    logic [3:0] oh;
    oh = 4'b1 << b;
    q_ack.push_back({1'b0, oh});
    for (int k = 0; k < 2; k++) begin
      logic [AW+1:0] ma;
      ma = {2'(b), a + AW'(k)};
      q_mem.push_back({1'b0, ma, 16'd0, 2'd0});
      exp_data = memf(ma);
      q_out.push_back({k == 0 ? oh : 4'd0, oh, k == 1 ? oh : 4'd0, 1'b0, exp_data});
    end
  endtask
  always @(negedge clk) if (mon_en && !rst) begin
    if (ba_ack != 0 || prog_ack)
      chk("ack", {prog_ack, ba_ack}, q_ack.size() != 0 ? q_ack.pop_front() : '1);
    if (mem_rd || mem_we)
      chk("mem", {mem_we, mem_addr, mem_we ? mem_din : 16'd0, mem_we ? mem_mask : 2'd0}, q_mem.size() != 0 ? q_mem.pop_front() : '1);
    if (ba_dok != 0 || prog_rdy)
      chk("out", {ba_dst, ba_dok, ba_rdy, prog_rdy, data_read}, q_out.size() != 0 ? q_out.pop_front() : '1);
    if ({ba_ack, ba_dst, ba_dok, ba_rdy} != 0)
      chk("onehot", {$onehot0(ba_ack), $onehot0(ba_dok), (ba_dst | ba_rdy) & ~ba_dok}, {2'b11, 4'd0});
  end
  task automatic wait_ack(input int b);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((b == 4) ? prog_ack : ba_ack[2'(b)]) return;
    end
    chk("ack_timeout", 0, 1);
  endtask
  task automatic drain();
    for (int i = 0; i < 400 && (q_ack.size() + q_mem.size() + q_out.size()) != 0; i++) @(negedge clk);
    chk("drain", q_ack.size() + q_mem.size() + q_out.size(), 0);
    repeat (3) @(negedge clk);
  endtask
  initial begin
    int n;
    logic seen;
    repeat (3) @(negedge clk);
    chk("rst_hold", outv(), 78'h3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out", outv(), 78'h3);
    mon_en = 1'b1;
    ba0_addr = 22'h100;
    ba1_addr = 22'h200;
    ba2_addr = 22'h300;
    ba3_addr = 22'h400;
    lat = 1;
    push_rd(0, 22'h100);
    push_rd(1, 22'h200);
    push_rd(2, 22'h300);
    push_rd(3, 22'h400);
    push_rd(0, 22'h100);
    ba_rd = 4'hF;
    n = 0;
    for (int i = 0; i < 400 && n < 5; i++) begin
      @(negedge clk);
      if (ba_ack != 0) n++;
    end
    ba_rd = 4'h0;
    drain();
    ba2_addr = 22'h1000;
    lat = 3;
    push_rd(2, 22'h1000);
    ba_rd[2] = 1'b1;
    wait_ack(2);
    ba_rd[2] = 1'b0;
    drain();
    ba1_addr = 22'h2222;
    prog_ba = 2'd3;
    prog_addr = 22'd5;
    prog_data = 16'hBEEF;
    prog_mask = 2'b10;
    q_ack.push_back(5'b10000);
    q_mem.push_back({1'b1, 2'd3, 22'd5, 16'hBEEF, 2'b10});
    q_out.push_back({12'd0, 1'b1, exp_data});
    push_rd(1, 22'h2222);
    prog_we = 1'b1;
    ba_rd[1] = 1'b1;
    wait_ack(4);
    prog_we = 1'b0;
    wait_ack(1);
    ba_rd[1] = 1'b0;
    drain();
    ba0_addr = 22'h3FFFFF;
    lat = 2;
    push_rd(0, 22'h3FFFFF);
    ba_rd[0] = 1'b1;
    wait_ack(0);
    ba_rd[0] = 1'b0;
    drain();
    n = 0;
    seen = 1'b0;
    ba_rd_1 = 4'b0001;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ba_ack_1[0]) ba_rd_1 = 4'b0000;
      if (mem_rd_1) n++;
      if (ba_dok_1 != 0) begin
        seen = 1'b1;
        chk("b1_strobes", {ba_dst_1, ba_dok_1, ba_rdy_1}, 12'h111);
        chk("b1_data", data_read_1, memf({2'd0, 22'h3FFFFF}));
        break;
      end
    end
    chk("b1_seen", seen, 1);
    repeat (4) begin
      @(negedge clk);
      if (mem_rd_1) n++;
    end
    chk("b1_nrd", n, 1);
    prog_ba = 2'd1;
    prog_addr = 22'd7;
    force_v = 16'hA55A;
    force_en = 1'b1;
    q_ack.push_back(5'b10000);
    q_mem.push_back({1'b0, 2'd1, 22'd7, 16'd0, 2'd0});
    exp_data = 16'hA55A;
    q_out.push_back({12'd0, 1'b1, 16'hA55A});
    prog_rd = 1'b1;
    wait_ack(4);
    prog_rd = 1'b0;
    drain();
    force_en = 1'b0;
    mon_en = 1'b0;
    ba3_addr = 22'h9;
    lat = 1;
    seen = 1'b0;
    ba_rd = 4'b1000;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ba_ack[3]) ba_rd = 4'b0000;
      if (mem_rd) begin
        seen = 1'b1;
        break;
      end
    end
    chk("abort_issue", seen, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_out0", outv(), 78'h3);
    @(negedge clk);
    chk("abort_out1", outv(), 78'h3);
    mon_en = 1'b1;
    push_rd(1, 22'h2222);
    ba_rd[1] = 1'b1;
    wait_ack(1);
    ba_rd[1] = 1'b0;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
